async_4ph_tx: RTL and testbench



---
 rtl/async_demo_pkg.sv | 16 +
 rtl/sync_ff.sv | 23 ++
 rtl/async_4ph_tx.sv | 153 +++++++++++++++
 tb/tb_async_4ph_tx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_demo_pkg.sv
// rtl/async_demo_pkg.sv - shared types and default sizes for the sync/async bridge blocks
package async_demo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        REQ_HI,
        REQ_LO
    } tx_state_t;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_SETUP_CYC   = 2;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-stage single-bit synchroniser, cleared by synchronous reset
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/async_4ph_tx.sv
// rtl/async_4ph_tx.sv - clocked FIFO feeding a 4-phase bundled-data Req/Ack channel
module async_4ph_tx
    import async_demo_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SETUP_CYC   = DEF_SETUP_CYC,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic [WIDTH-1:0]           InData,
    output logic                       Req,
    input  logic                       Ack,
    output logic [WIDTH-1:0]           Data,
    output logic                       Busy,
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(SETUP_CYC + 1);
    localparam int WW = $clog2(SYNC_STAGES + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic             ack_s;
    logic             warm;
    logic [WW-1:0]    warm_cnt;
    logic [SW-1:0]    cnt;
    logic [SW-1:0]    cnt_next;
    logic             req_next;
    tx_state_t        state;
    tx_state_t        state_next;

    sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (Clk),
        .reset (Reset),
        .d     (Ack),
        .q     (ack_s)
    );

    assign InReady = (Count != CW'(DEPTH));
    assign push    = InValid && InReady;
    assign Busy    = (state != IDLE);
    assign warm    = (warm_cnt == WW'(SYNC_STAGES));

    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= InData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   Count <= Count + CW'(1);
                2'b01:   Count <= Count - CW'(1);
                default: Count <= Count;
            endcase
        end
    end

    // The synchroniser restarts at 0 after reset, so ack_s is not trusted until
    // the chain has refilled; otherwise a stale high Ack would read as low.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            warm_cnt <= '0;
        end else if (!warm) begin
            warm_cnt <= warm_cnt + WW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            Req   <= 1'b0;
            Data  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            Req   <= req_next;
            if (pop) begin
                Data <= mem[rd_ptr];
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        req_next   = Req;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                req_next = 1'b0;
                if (warm && (Count != '0) && !ack_s) begin
                    pop        = 1'b1;
                    cnt_next   = SW'(SETUP_CYC - 1);
                    state_next = SETUP;
                end
            end
            SETUP: begin
                // Ack is deliberately not looked at here; early pulses are ignored.
                if (cnt == '0) begin
                    req_next   = 1'b1;
                    state_next = REQ_HI;
                end else begin
                    req_next = 1'b0;
                    cnt_next = cnt - SW'(1);
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    req_next   = 1'b0;
                    state_next = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    if (Count != '0) begin
                        pop        = 1'b1;
                        cnt_next   = SW'(SETUP_CYC - 1);
                        state_next = SETUP;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_async_4ph_tx.sv
// tb/tb_async_4ph_tx.sv - directed self-checking bench for async_4ph_tx
module tb_async_4ph_tx;

    localparam int WIDTH       = 8;
    localparam int DEPTH       = 4;
    localparam int SETUP_CYC   = 2;
    localparam int SYNC_STAGES = 2;
    localparam int CW          = $clog2(DEPTH + 1);

    logic             Clk     = 1'b0;
    logic             Reset   = 1'b1;
    logic             InValid = 1'b0;
    logic [WIDTH-1:0] InData  = '0;
    logic             Ack     = 1'b0;
    logic             InReady;
    logic             Req;
    logic [WIDTH-1:0] Data;
    logic             Busy;
    logic [CW-1:0]    Count;

    async_4ph_tx #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .SETUP_CYC   (SETUP_CYC),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .InValid (InValid),
        .InReady (InReady),
        .InData  (InData),
        .Req     (Req),
        .Ack     (Ack),
        .Data    (Data),
        .Busy    (Busy),
        .Count   (Count)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    always @(posedge Clk) edge_n <= edge_n + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, act, exp, edge_n);
        end
    endtask

    logic [WIDTH-1:0] exp_q[$];
    int               rises = 0;

    // Ack responder: raises Ack resp_dly cycles after Req rises, drops it resp_dly cycles after Req falls
    bit resp_en  = 1'b0;
    int resp_dly = 3;
    int rphase   = 0;
    int rcnt     = 0;

    always @(negedge Clk) begin
        if (!resp_en) begin
            rphase = 0;
        end else begin
            case (rphase)
                0: if (Req) begin rcnt = resp_dly - 1; rphase = 1; end
                1: if (rcnt == 0) begin Ack = 1'b1; rphase = 2; end else rcnt--;
                2: if (!Req) begin rcnt = resp_dly - 1; rphase = 3; end
                3: if (rcnt == 0) begin Ack = 1'b0; rphase = 0; end else rcnt--;
                default: rphase = 0;
            endcase
        end
    end

    // Protocol monitor: ack_hist[1] at sample n is the Ack value the DUT's ack_s presents at edge n
    logic             req_p    = 1'b0;
    logic [WIDTH-1:0] data_p   = '0;
    logic             ready_p  = 1'b1;
    logic             ack_p    = 1'b0;
    logic [3:0]       ack_hist = '0;
    int               stab     = 0;
    int               cnt_m    = 0;
    int               ack_rise_edge = -100;
    bit               early    = 1'b0;
    bit               pushed;
    bit               popped;

    always @(posedge Clk) begin
        #2;
        if (Reset) begin
            check("rst_req", Req, 0);
            check("rst_count", Count, 0);
            check("rst_data", Data, 0);
            cnt_m = 0;
            stab  = 0;
        end else begin
            pushed = InValid && ready_p;
            popped = (Data != data_p);
            if (popped) begin
                check("pop_req_low", {req_p, Req}, 0);
                check("pop_ack_s_low", ack_hist[1], 0);
                stab = 0;
            end else begin
                stab++;
            end
            cnt_m = cnt_m + int'(pushed) - int'(popped);
            check("count_model", Count, cnt_m);
            if (Req && !req_p) begin
                rises++;
                check("setup_hold", stab >= SETUP_CYC, 1);
                if (!early) check("rise_ack_s_low", ack_hist[1], 0);
                check("rise_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("rise_data", Data, exp_q.pop_front());
            end
            if (!Req && req_p) check("fall_latency", edge_n - ack_rise_edge, SYNC_STAGES);
        end
        if (Ack && !ack_p) ack_rise_edge = edge_n;
        ack_hist = {ack_hist[2:0], Ack};
        ack_p    = Ack;
        req_p    = Req;
        data_p   = Data;
        ready_p  = InReady;
    end

    // Called on a negedge; the word is taken at the next posedge, returns on the following negedge.
    task automatic push_word(input logic [WIDTH-1:0] w);
        InValid = 1'b1;
        InData  = w;
        if (InReady) exp_q.push_back(w);
        @(posedge Clk);
        @(negedge Clk);
        InValid = 1'b0;
    endtask

    task automatic wait_req(input logic v, input int budget, input string tag);
        int i = 0;
        while (Req !== v && i < budget) begin
            @(negedge Clk);
            i++;
        end
        check(tag, Req, v);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int i = 0;
        while ((Busy || Count != '0 || exp_q.size() != 0) && i < budget) begin
            @(negedge Clk);
            i++;
        end
        check(tag, {Busy, Count, exp_q.size() != 0}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int               r0;
    logic [CW-1:0]    c0;
    logic [WIDTH-1:0] d0;

    initial begin
        repeat (3) @(negedge Clk);
        check("reset_req", Req, 0);
        check("reset_data", Data, 0);
        check("reset_busy", Busy, 0);
        check("reset_count", Count, 0);
        check("reset_inready", InReady, 1);
        Reset = 1'b0;

        // Single word pushed at edge 10
        while (edge_n < 9) @(negedge Clk);
        push_word(8'hA5);
        check("t1_count_push", Count, 1);
        @(negedge Clk);
        check("t1_data_k1", Data, 8'hA5);
        check("t1_busy_k1", Busy, 1);
        check("t1_req_k1", Req, 0);
        check("t1_count_k1", Count, 0);
        @(negedge Clk);
        check("t1_req_k2", Req, 0);
        @(negedge Clk);
        check("t1_req_k3", Req, 1);
        resp_en = 1'b1;
        wait_req(0, 30, "t1_req_fall");
        wait_idle(30, "t1_idle");

        // Burst to full with Ack held low
        resp_en = 1'b0;
        r0 = rises;
        for (int i = 1; i <= 5; i++) push_word(WIDTH'(i));
        check("t2_count_full", Count, 4);
        check("t2_inready_full", InReady, 0);
        check("t2_req_hi", Req, 1);
        check("t2_data_first", Data, 8'h01);
        InValid = 1'b1;
        InData  = 8'h06;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("t2_stall_count", Count, 4);
            check("t2_stall_inready", InReady, 0);
        end
        InValid = 1'b0;
        resp_en = 1'b1;
        wait_idle(300, "t2_drain");
        check("t2_rises", rises - r0, 5);

        // Pushes landing on REQ_LO pops, three FIFO laps
        r0 = rises;
        push_word(8'h10);
        push_word(8'h11);
        for (int i = 2; i < 12; i++) begin
            wait_req(1, 40, "t3_rise");
            wait_req(0, 40, "t3_fall");
            repeat (5) @(negedge Clk);
            c0 = Count;
            d0 = Data;
            push_word(WIDTH'(8'h10 + i));
            check("t3_simul_count", Count, c0);
            check("t3_simul_pop", Data != d0, 1);
        end
        wait_idle(100, "t3_drain");
        check("t3_rises", rises - r0, 12);

        // Reset in REQ_HI with a stale high Ack
        resp_en = 1'b0;
        push_word(8'h77);
        wait_req(1, 20, "t4_rise");
        Ack   = 1'b1;
        Reset = 1'b1;
        @(negedge Clk);
        check("t4_rst_req", Req, 0);
        check("t4_rst_count", Count, 0);
        check("t4_rst_busy", Busy, 0);
        Reset = 1'b0;
        exp_q.delete();
        push_word(8'h3C);
        for (int i = 0; i < 9; i++) begin
            @(negedge Clk);
            check("t4_hold_req", Req, 0);
        end
        Ack = 1'b0;
        for (int i = 0; i < SYNC_STAGES + SETUP_CYC; i++) begin
            @(negedge Clk);
            check("t4_wait_req", Req, 0);
        end
        @(negedge Clk);
        check("t4_req_rise", Req, 1);
        check("t4_data", Data, 8'h3C);
        resp_en = 1'b1;
        wait_idle(40, "t4_idle");

        // One-cycle Ack pulse while in SETUP
        resp_en = 1'b0;
        early   = 1'b1;
        push_word(8'h5A);
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        check("t5_setup_req", Req, 0);
        check("t5_setup_busy", Busy, 1);
        @(negedge Clk);
        check("t5_req_k2", Req, 0);
        @(negedge Clk);
        check("t5_req_k3", Req, 1);
        repeat (6) @(negedge Clk);
        check("t5_req_held", Req, 1);
        check("t5_data_held", Data, 8'h5A);
        resp_en = 1'b1;
        wait_req(0, 30, "t5_req_fall");
        wait_idle(30, "t5_idle");
        early = 1'b0;

        repeat (3) @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
